mem_bus_master: RTL and testbench
=================================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles the master waits for busy to deassert before it aborts a transaction.
REQ-002 Parameter IO_ADDR0, default 32'h00000FFC: IO address that the memory responder does not service.
REQ-003 Parameter IO_ADDR1, default 32'h00001FFC: second IO address that the memory responder does not service.
REQ-004 clk  in  1: single clock; all logic on posedge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 cmd_valid  in  1: command request.
REQ-007 cmd_ready  out  1: command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_write  in  1: 1 = write, 0 = read.
REQ-009 cmd_addr  in  32: byte address.
REQ-010 cmd_wdata  in  32: write data.
REQ-011 cmd_wmask  in  4: write byte enables.
REQ-012 rsp_valid  out  1: response available.
REQ-013 rsp_ready  in  1: response consumed when rsp_valid and rsp_ready are both high.
REQ-014 rsp_rdata  out  32: read data; 0 for writes and errors.
REQ-015 rsp_err  out  1: transaction rejected or timed out.
REQ-016 mem_addr  out  32: bus address.
REQ-017 mem_wdata  out  32: bus write data.
REQ-018 mem_wmask  out  4: bus write mask; nonzero with mem_rstrb low means write.
REQ-019 mem_rstrb  out  1: read strobe.
REQ-020 mem_rdata  in  32: bus read data.
REQ-021 mem_rbusy  in  1: responder read busy.
REQ-022 mem_wbusy  in  1: responder write busy.

Function
REQ-023 The master SHALL implement FSM states IDLE, ISSUE, SETTLE, WAIT and RESP.
REQ-024 cmd_ready SHALL be 1 only in IDLE; at most one transaction is outstanding.
REQ-025 On acceptance, addr, wdata, wmask and write SHALL be registered; mem_addr and mem_wdata SHALL hold the registered values from ISSUE until RESP is exited.
REQ-026 Accepted commands are classified as follows, and any of these SHALL go IDLE->RESP directly with no bus activity (mem_rstrb=0, mem_wmask=0):
- cmd_addr[1:0]!=0, or cmd_addr equal to IO_ADDR0 or IO_ADDR1: rsp_err=1.
- write with cmd_wmask==0: rsp_err=0.
REQ-027 All other accepted commands SHALL go IDLE->ISSUE.
REQ-028 In ISSUE, for exactly one cycle, the master SHALL drive mem_rstrb=1 and mem_wmask=0 for a read, or mem_rstrb=0 and mem_wmask=registered mask for a write; next state is SETTLE.
REQ-029 Outside ISSUE, mem_rstrb SHALL be 0 and mem_wmask SHALL be 0.
REQ-030 SETTLE SHALL last one cycle, ignore busy (the responder's busy is registered and lags the request) and go to WAIT.
REQ-031 WAIT SHALL poll busy (mem_rbusy for reads, mem_wbusy for writes). When the selected busy is 0, the master SHALL capture mem_rdata into rsp_rdata (read) or 0 (write), set rsp_err=0 and go to RESP in the same cycle.
REQ-032 An 8-bit wait counter SHALL clear on entry to SETTLE and increment each WAIT cycle with busy high. When it reaches TIMEOUT, the master SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-033 A busy deassertion in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-034 In RESP, rsp_valid SHALL be 1 and rsp_rdata and rsp_err SHALL be stable; on rsp_ready, the master SHALL return to IDLE.
REQ-035 A new command SHALL NOT be accepted in the RESP-exit cycle; minimum spacing is one IDLE cycle.
REQ-036 A busy pulse arriving while in IDLE or RESP SHALL be ignored.
REQ-037 Minimum read or write latency SHALL be 4 cycles from acceptance to rsp_valid (ISSUE, SETTLE, WAIT, RESP), given an immediately ready responder.

Reset
REQ-038 On reset, the state SHALL go to IDLE and the outputs SHALL be: cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_wdata=0, mem_wmask=0, mem_rstrb=0; the wait counter SHALL be cleared.
REQ-039 Reset asserted mid-transaction SHALL abandon the transaction with no response, and mem_rstrb and mem_wmask SHALL be 0 in the following cycle.

Verification
REQ-040 Read addr 0x00000010, responder returns 0xDEADBEEF, rbusy high 1 cycle -> mem_rstrb single pulse, mem_addr=0x10 held, rsp_valid with rdata=0xDEADBEEF, err=0.
REQ-041 Write addr 0x20, wdata 0x12345678, wmask 4'b0011 -> mem_wmask=0011 for exactly one cycle, mem_rstrb=0, rsp_valid with err=0, rdata=0.
REQ-042 Command to 0x00000FFC, to 0x1FFC, and to 0x22 -> no mem_rstrb or mem_wmask activity, rsp_err=1 one cycle after acceptance.
REQ-043 rbusy held high indefinitely with TIMEOUT=64 -> rsp_err=1 after 64 WAIT cycles; busy dropping on cycle 64 -> err=0.
REQ-044 rsp_ready held low 10 cycles -> rsp_valid, rdata and err stable and cmd_ready=0 throughout; cmd_ready rises the cycle after the handshake.
REQ-045 Reset asserted during WAIT -> all outputs at reset values the next cycle, no rsp_valid, a subsequent read completes normally.

Source files
------------

// File: rtl/mem_bus_if.sv
// Command/response/memory-bus bundle for mem_bus_master.
// The master modport drives cmd_ready, the rsp_* outputs and the mem_* request
// signals. The slave modport is the mirror view, for a command source that is
// also the memory responder.
interface mem_bus_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // memory bus
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask,
    input  rsp_ready,
    input  mem_rdata, mem_rbusy, mem_wbusy,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask,
    output rsp_ready,
    output mem_rdata, mem_rbusy, mem_wbusy,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb
  );
endinterface

// File: rtl/mem_bus_master.sv
// Single-outstanding memory bus master.
// Each command is accepted in IDLE. It then takes one of two paths:
//  - Misaligned addresses, the two IO addresses and empty writes go straight
//    to RESP with no bus activity.
//  - All other commands issue a one-cycle strobe, wait one SETTLE cycle for
//    the responder's registered busy to catch up, then poll busy with a
//    timeout.
module mem_bus_master #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] IO_ADDR0 = 32'h0000_0FFC,
  parameter logic [31:0] IO_ADDR1 = 32'h0000_1FFC
) (
  input  logic      clk,
  input  logic      reset,
  mem_bus_if.master bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        write_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic        accept;
  logic        addr_bad;
  logic        busy_sel;

  assign accept   = bus.cmd_valid && (state_q == S_IDLE);
  assign addr_bad = (bus.cmd_addr[1:0] != 2'b00) ||
                    (bus.cmd_addr == IO_ADDR0) ||
                    (bus.cmd_addr == IO_ADDR1);
  assign busy_sel = write_q ? bus.mem_wbusy : bus.mem_rbusy;

  // State, captured command, and response/counter registers.
  // NOTE: reset is synchronous here: it is sampled only on the clock edge and
  // therefore sits inside the clocked branch, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
        wmask_q <= bus.cmd_wmask;
        write_q <= bus.cmd_write;
      end
    end
  end

  // Next-state logic: command classification, busy polling and timeout.
  always_comb begin
    // NOTE: defaults first, so no path through the case can infer a latch.
    state_d    = state_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (addr_bad) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (bus.cmd_write && (bus.cmd_wmask == 4'b0000)) begin
            state_d = S_RESP;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d    = S_SETTLE;
        wait_cnt_d = '0;
      end
      S_SETTLE: begin
        // Busy still reflects the previous request here, so ignore it.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!busy_sel) begin
          // Success wins over a timeout that would expire in the same cycle.
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = write_q ? 32'h0 : bus.mem_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d == TIMEOUT_CNT) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes only in ISSUE, response fields straight from registers.
  always_comb begin
    bus.cmd_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_rstrb = (state_q == S_ISSUE) && !write_q;
    bus.mem_wmask = ((state_q == S_ISSUE) && write_q) ? wmask_q : 4'b0000;
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed testbench for mem_bus_master.
// A small responder model raises busy one cycle after each strobe, for a
// programmable number of cycles. Stimulus is driven and outputs are sampled
// on the falling edge.
module tb_mem_bus_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_if bus();

  mem_bus_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // responder model: registered busy, lagging the strobe by one cycle
  int          rd_len = 1;
  int          wr_len = 1;
  int          rd_left = 0;
  int          wr_left = 0;
  logic        hold_rbusy = 1'b0;
  logic [31:0] rd_value = 32'h0;

  always @(posedge clk) begin
    if (bus.mem_rstrb) rd_left <= rd_len;
    else if (rd_left > 0) rd_left <= rd_left - 1;
    if (bus.mem_wmask != 4'b0000) wr_left <= wr_len;
    else if (wr_left > 0) wr_left <= wr_left - 1;
  end

  assign bus.mem_rbusy = (rd_left > 0) || hold_rbusy;
  assign bus.mem_wbusy = (wr_left > 0);
  assign bus.mem_rdata = rd_value;

  // bus activity monitor
  int          rstrb_cnt = 0;
  int          wmask_cnt = 0;
  logic [31:0] strobe_addr = '0;
  logic [31:0] strobe_wdata = '0;
  logic [3:0]  strobe_mask = '0;

  always @(negedge clk) begin
    if (bus.mem_rstrb) begin
      rstrb_cnt   <= rstrb_cnt + 1;
      strobe_addr <= bus.mem_addr;
    end
    if (bus.mem_wmask != 4'b0000) begin
      wmask_cnt    <= wmask_cnt + 1;
      strobe_mask  <= bus.mem_wmask;
      strobe_addr  <= bus.mem_addr;
      strobe_wdata <= bus.mem_wdata;
    end
  end

  // Presents one command (called on a falling edge). Returns the latency in
  // cycles from acceptance to the first cycle with rsp_valid.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int lat);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wmask = m;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Completes the response handshake and checks the return to IDLE.
  task automatic finish_rsp(input string name);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s_handshake: ready/valid=%b required 10", name, {bus.cmd_ready, bus.rsp_valid});
    end
  endtask

  task automatic test_reset();
    logic [103:0] got;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_addr,
           bus.mem_wdata, bus.mem_wmask, bus.mem_rstrb};
    vectors++;
    if (got !== {1'b1, 103'h0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required %h", got, {1'b1, 103'h0});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int lat;
    rstrb_cnt = 0; wmask_cnt = 0;
    rd_value = 32'hDEAD_BEEF; rd_len = 1;
    send_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL read_latency: got %0d required 4", lat); end
    vectors++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_rdata: got %h required deadbeef", bus.rsp_rdata); end
    vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL read_err: got %b required 0", bus.rsp_err); end
    vectors++; if ({rstrb_cnt, wmask_cnt} !== {32'd1, 32'd0}) begin miscompares++; $display("FAIL read_strobes: rstrb %0d wmask %0d required 1 0", rstrb_cnt, wmask_cnt); end
    vectors++; if ({strobe_addr, bus.mem_addr} !== {32'h10, 32'h10}) begin miscompares++; $display("FAIL read_addr_hold: strobe %h resp %h required 10", strobe_addr, bus.mem_addr); end
    finish_rsp("read");
  endtask

  task automatic test_write();
    int lat;
    rstrb_cnt = 0; wmask_cnt = 0;
    wr_len = 1;
    send_cmd(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL write_latency: got %0d required 4", lat); end
    vectors++; if ({bus.rsp_err, bus.rsp_rdata} !== 33'h0) begin miscompares++; $display("FAIL write_rsp: err %b rdata %h required 0 0", bus.rsp_err, bus.rsp_rdata); end
    vectors++; if ({rstrb_cnt, wmask_cnt} !== {32'd0, 32'd1}) begin miscompares++; $display("FAIL write_strobes: rstrb %0d wmask %0d required 0 1", rstrb_cnt, wmask_cnt); end
    vectors++; if ({strobe_mask, strobe_wdata, strobe_addr} !== {4'b0011, 32'h1234_5678, 32'h20}) begin miscompares++; $display("FAIL write_bus: mask %b wdata %h addr %h", strobe_mask, strobe_wdata, strobe_addr); end
    finish_rsp("write");
  endtask

  task automatic test_reject();
    logic [31:0] addrs [4] = '{32'h0000_0FFC, 32'h0000_1FFC, 32'h0000_0022, 32'h0000_0030};
    logic        wr    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  msk   [4] = '{4'hF, 4'hF, 4'hF, 4'h0};
    logic        exp_e [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int lat;
    rd_value = 32'hA5A5_A5A5;
    for (int i = 0; i < 4; i++) begin
      rstrb_cnt = 0; wmask_cnt = 0;
      send_cmd(wr[i], addrs[i], 32'hFFFF_FFFF, msk[i], lat);
      vectors++;
      if ({lat, bus.rsp_err, bus.rsp_rdata, rstrb_cnt, wmask_cnt} !==
          {32'd1, exp_e[i], 32'h0, 32'd0, 32'd0}) begin
        miscompares++;
        $display("FAIL reject_%0d: lat %0d err %b rdata %h rstrb %0d wmask %0d required lat 1 err %b rdata 0 no strobes",
                 i, lat, bus.rsp_err, bus.rsp_rdata, rstrb_cnt, wmask_cnt, exp_e[i]);
      end
      finish_rsp("reject");
    end
  endtask

  task automatic test_timeout();
    int lat;
    rd_value = 32'h0BAD_F00D;
    // busy stuck high: 64 WAIT cycles then error
    hold_rbusy = 1'b1;
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'h0, lat);
    hold_rbusy = 1'b0;
    vectors++; if ({lat, bus.rsp_err, bus.rsp_rdata} !== {32'd67, 1'b1, 32'h0}) begin miscompares++; $display("FAIL timeout_stuck: lat %0d err %b rdata %h required 67 1 0", lat, bus.rsp_err, bus.rsp_rdata); end
    finish_rsp("timeout");
    // busy drops on WAIT cycle 64: success
    rd_len = 64;
    send_cmd(1'b0, 32'h0000_0104, 32'h0, 4'h0, lat);
    vectors++; if ({lat, bus.rsp_err, bus.rsp_rdata} !== {32'd67, 1'b0, 32'h0BAD_F00D}) begin miscompares++; $display("FAIL timeout_edge_ok: lat %0d err %b rdata %h required 67 0 0badf00d", lat, bus.rsp_err, bus.rsp_rdata); end
    finish_rsp("timeout");
    // busy high through WAIT cycle 64: error
    rd_len = 65;
    send_cmd(1'b0, 32'h0000_0108, 32'h0, 4'h0, lat);
    vectors++; if ({lat, bus.rsp_err, bus.rsp_rdata} !== {32'd67, 1'b1, 32'h0}) begin miscompares++; $display("FAIL timeout_edge_err: lat %0d err %b rdata %h required 67 1 0", lat, bus.rsp_err, bus.rsp_rdata); end
    finish_rsp("timeout");
    rd_len = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    rd_value = 32'h5555_AAAA;
    send_cmd(1'b0, 32'h0000_0200, 32'h0, 4'h0, lat);
    rd_value = 32'h1111_2222;  // bus data changes; the response must not
    hold_rbusy = 1'b1;         // stray busy while in RESP
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready} !== {1'b1, 32'h5555_AAAA, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL hold_cycle_%0d: valid %b rdata %h err %b cmd_ready %b required 1 5555aaaa 0 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready);
      end
      @(negedge clk);
    end
    hold_rbusy = 1'b0;
    finish_rsp("hold");
  endtask

  task automatic test_stray_busy();
    int lat;
    hold_rbusy = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if ({bus.cmd_ready, bus.rsp_valid, bus.mem_rstrb} !== 3'b100) begin miscompares++; $display("FAIL idle_busy: ready/valid/rstrb %b required 100", {bus.cmd_ready, bus.rsp_valid, bus.mem_rstrb}); end
    hold_rbusy = 1'b0;
    rd_value = 32'h7777_0001;
    send_cmd(1'b0, 32'h0000_0300, 32'h0, 4'h0, lat);
    vectors++; if ({lat, bus.rsp_rdata} !== {32'd4, 32'h7777_0001}) begin miscompares++; $display("FAIL idle_busy_read: lat %0d rdata %h required 4 77770001", lat, bus.rsp_rdata); end
    finish_rsp("stray");
  endtask

  task automatic test_back_to_back();
    int lat;
    rd_value = 32'h0000_00A1;
    send_cmd(1'b0, 32'h0000_0400, 32'h0, 4'h0, lat);
    // second command already waiting while the first response completes
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0404;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    vectors++; if ({bus.cmd_ready, bus.rsp_valid, bus.mem_rstrb} !== 3'b100) begin miscompares++; $display("FAIL b2b_gap: ready/valid/rstrb %b required 100", {bus.cmd_ready, bus.rsp_valid, bus.mem_rstrb}); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rd_value = 32'h0000_00B2;
    vectors++; if ({bus.mem_rstrb, bus.mem_addr, bus.cmd_ready} !== {1'b1, 32'h404, 1'b0}) begin miscompares++; $display("FAIL b2b_issue: rstrb %b addr %h ready %b required 1 404 0", bus.mem_rstrb, bus.mem_addr, bus.cmd_ready); end
    lat = 1;
    while (!bus.rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    vectors++; if ({lat, bus.rsp_rdata} !== {32'd4, 32'h0000_00B2}) begin miscompares++; $display("FAIL b2b_second: lat %0d rdata %h required 4 b2", lat, bus.rsp_rdata); end
    finish_rsp("b2b");
  endtask

  task automatic test_reset_mid();
    logic [103:0] got;
    int lat;
    int seen;
    hold_rbusy = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0500;
    @(negedge clk);   // ISSUE
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);  // SETTLE, WAIT, WAIT, WAIT
    reset = 1'b1;
    @(negedge clk);
    got = {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_addr,
           bus.mem_wdata, bus.mem_wmask, bus.mem_rstrb};
    vectors++; if (got !== {1'b1, 103'h0}) begin miscompares++; $display("FAIL midreset_outputs: got %h required %h", got, {1'b1, 103'h0}); end
    reset = 1'b0;
    hold_rbusy = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (bus.rsp_valid) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midreset_no_rsp: rsp_valid cycles %0d required 0", seen); end
    rd_value = 32'hCAFE_F00D; rd_len = 1;
    send_cmd(1'b0, 32'h0000_0504, 32'h0, 4'h0, lat);
    vectors++; if ({lat, bus.rsp_rdata, bus.rsp_err} !== {32'd4, 32'hCAFE_F00D, 1'b0}) begin miscompares++; $display("FAIL midreset_read: lat %0d rdata %h err %b required 4 cafef00d 0", lat, bus.rsp_rdata, bus.rsp_err); end
    finish_rsp("midreset");
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_wmask = '0;   bus.rsp_ready = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_reject();
    test_timeout();
    test_backpressure();
    test_stray_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
